cnt_stim_seq: RTL and testbench

//  Synthesizable, command-driven stimulus sequencer and self-checker for an N-bit universal counter.

---
 rtl/cnt_stim_seq_if.sv | 25 ++
 rtl/cnt_stim_seq.sv | 173 +++++++++++++++++
 tb/tb_cnt_stim_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_stim_seq_if.sv
// rtl/cnt_stim_seq_if.sv - command channel into the counter stimulus sequencer
`timescale 1ns/1ps

interface cnt_stim_seq_if #(
    parameter int N = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/cnt_stim_seq.sv
// rtl/cnt_stim_seq.sv - command-driven stimulus sequencer and self-checker for a universal counter
`timescale 1ns/1ps

module cnt_stim_seq #(
    parameter int N     = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    cnt_stim_seq_if.slave    cmd,
    output logic             syn_clr,
    output logic             load,
    output logic             en,
    output logic             up,
    output logic [N-1:0]     d,
    input  logic [N-1:0]     dut_q,
    input  logic             chk_en,
    input  logic             err_clr,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     exp_q,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       OP_UP   = 2'b00;
    localparam logic [1:0]       OP_DN   = 2'b01;
    localparam logic [1:0]       OP_LOAD = 2'b10;
    localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ONE_E   = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t       state, state_nxt;
    logic [N-1:0] rem, rem_nxt;
    logic         ready_q, ready_nxt;
    logic         syn_clr_nxt, load_nxt, en_nxt, up_nxt;
    logic [N-1:0] d_nxt;
    logic         busy_nxt, done_nxt;
    logic         accept;

    assign cmd.cmd_ready = ready_q;
    assign accept        = cmd.cmd_valid && ready_q;

    // State and every control output are registered; an abort by reset leaves nothing to resume
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            rem     <= '0;
            ready_q <= 1'b1;
            syn_clr <= 1'b0;
            load    <= 1'b0;
            en      <= 1'b0;
            up      <= 1'b0;
            d       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rem     <= rem_nxt;
            ready_q <= ready_nxt;
            syn_clr <= syn_clr_nxt;
            load    <= load_nxt;
            en      <= en_nxt;
            up      <= up_nxt;
            d       <= d_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Next state and next control values; DONE behaves like IDLE for acceptance
    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem;
        ready_nxt   = ready_q;
        syn_clr_nxt = syn_clr;
        load_nxt    = load;
        en_nxt      = en;
        up_nxt      = up;
        d_nxt       = d;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        case (state)
            S_RUN: begin
                rem_nxt = rem - ONE_N;
                if (rem == ONE_N) begin
                    syn_clr_nxt = 1'b0;
                    load_nxt    = 1'b0;
                    en_nxt      = 1'b0;
                    up_nxt      = 1'b0;
                    done_nxt    = 1'b1;
                    ready_nxt   = 1'b1;
                    state_nxt   = S_DONE;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                ready_nxt   = 1'b1;
                busy_nxt    = 1'b0;
                syn_clr_nxt = 1'b0;
                load_nxt    = 1'b0;
                en_nxt      = 1'b0;
                up_nxt      = 1'b0;
                if (accept) begin
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    case (cmd.cmd_op)
                        OP_UP, OP_DN: begin
                            if (cmd.cmd_arg == '0) begin
                                // Zero-length count completes without any enable cycle
                                done_nxt  = 1'b1;
                                ready_nxt = 1'b1;
                                state_nxt = S_DONE;
                            end else begin
                                en_nxt    = 1'b1;
                                up_nxt    = (cmd.cmd_op == OP_UP);
                                rem_nxt   = cmd.cmd_arg;
                                state_nxt = S_RUN;
                            end
                        end
                        OP_LOAD: begin
                            load_nxt  = 1'b1;
                            d_nxt     = cmd.cmd_arg;
                            rem_nxt   = ONE_N;
                            state_nxt = S_RUN;
                        end
                        default: begin
                            syn_clr_nxt = 1'b1;
                            rem_nxt     = ONE_N;
                            state_nxt   = S_RUN;
                        end
                    endcase
                end
            end
        endcase
    end

    // Reference model tracks the counter from the same registered controls the DUT sees
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q <= '0;
        end else if (syn_clr) begin
            exp_q <= '0;
        end else if (load) begin
            exp_q <= d;
        end else if (en) begin
            exp_q <= up ? (exp_q + ONE_N) : (exp_q - ONE_N);
        end
    end

    // Mismatch checker; an explicit clear beats a mismatch in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (err_clr) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (chk_en && (dut_q != exp_q)) begin
            err <= 1'b1;
            if (err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + ONE_E;
            end
        end
    end

endmodule

// File: tb/tb_cnt_stim_seq.sv
// tb/tb_cnt_stim_seq.sv - scoreboard bench for cnt_stim_seq driving a behavioural counter
`timescale 1ns/1ps

module tb_cnt_stim_seq;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         syn_clr, load, en, up;
    logic [N-1:0] d;
    logic [N-1:0] dut_q;
    logic         chk_en, err_clr;
    logic         busy, done;
    logic [N-1:0] exp_q;
    logic         err;
    logic [7:0]   err_cnt;

    cnt_stim_seq_if #(.N(N)) cif ();

    cnt_stim_seq #(.N(N), .ERR_W(8)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .cmd     (cif.slave),
        .syn_clr (syn_clr),
        .load    (load),
        .en      (en),
        .up      (up),
        .d       (d),
        .dut_q   (dut_q),
        .chk_en  (chk_en),
        .err_clr (err_clr),
        .busy    (busy),
        .done    (done),
        .exp_q   (exp_q),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Universal counter under test, with a bit-flip hook for fault injection
    logic [N-1:0] cnt_r;
    logic [N-1:0] flip;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cnt_r <= '0;
        else if (syn_clr) cnt_r <= '0;
        else if (load)    cnt_r <= d;
        else if (en)      cnt_r <= up ? cnt_r + 8'd1 : cnt_r - 8'd1;
    end
    assign dut_q = cnt_r ^ flip;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    typedef struct {
        int   q;
        int   en_n;
        logic up;
        int   ld_n;
        int   clr_n;
        int   dv;
        int   lat;
    } exp_t;

    exp_t sb[$];
    int   mv = 0;
    int   done_seen = 0;

    // Monitor: tallies control activity per command and settles it against the scoreboard at done
    int m_en = 0, m_ld = 0, m_clr = 0, m_busy = 0, m_up_bad = 0, m_d_bad = 0;
    always @(negedge clk) begin
        if (!reset) begin
            m_en = 0; m_ld = 0; m_clr = 0; m_busy = 0; m_up_bad = 0; m_d_bad = 0;
        end else begin
            chk("one_hot_ctl", (int'(syn_clr) + int'(load) + int'(en)) <= 1, 1);
            if (en) begin
                m_en++;
                if (sb.size() > 0 && up != sb[0].up) m_up_bad++;
            end
            if (load) begin
                m_ld++;
                if (sb.size() > 0 && int'(d) != sb[0].dv) m_d_bad++;
            end
            if (syn_clr) m_clr++;
            if (busy) m_busy++;
            if (done) begin
                done_seen++;
                chk("done_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("exp_q", exp_q, e.q);
                    chk("dut_q", dut_q, e.q);
                    chk("en_cycles", m_en, e.en_n);
                    chk("load_cycles", m_ld, e.ld_n);
                    chk("clr_cycles", m_clr, e.clr_n);
                    chk("busy_cycles", m_busy, e.lat);
                    chk("up_dir_bad", m_up_bad, 0);
                    chk("load_data_bad", m_d_bad, 0);
                    chk("ctl_idle_at_done", {syn_clr, load, en}, 0);
                    chk("ready_at_done", cif.cmd_ready, 1);
                end
                m_en = 0; m_ld = 0; m_clr = 0; m_busy = 0; m_up_bad = 0; m_d_bad = 0;
            end
        end
    end

    // Issue one command; expectation is computed from plain arithmetic on the running value
    task automatic send(input logic [1:0] op, input int arg);
        int   t = 0;
        exp_t e;
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_arg   = arg[N-1:0];
        while (!cif.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", t < 200, 1);
        e.up = 1'b0; e.en_n = 0; e.ld_n = 0; e.clr_n = 0; e.dv = -1; e.lat = 2;
        case (op)
            2'b00: begin mv = (mv + arg) % 256;       e.en_n = arg; e.up = 1'b1; e.lat = arg + 1; end
            2'b01: begin mv = (mv - arg + 256) % 256; e.en_n = arg; e.lat = arg + 1; end
            2'b10: begin mv = arg;                    e.ld_n = 1; e.dv = arg; end
            default: begin mv = 0;                    e.clr_n = 1; end
        endcase
        e.q = mv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sb.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        cif.cmd_arg   = '0;
        chk_en        = 1'b1;
        err_clr       = 1'b0;
        flip          = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ctl", {syn_clr, load, en, up, busy, done, err}, 0);
        chk("rst_d", d, 0);
        chk("rst_exp_q", exp_q, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_ready", cif.cmd_ready, 1);

        // Directed: counting up, down with wrap, load then count, clear then zero-length count
        send(2'b00, 12);
        wait_idle();
        chk("t1_exp_q", exp_q, 12);
        chk("t1_err", err, 0);
        send(2'b01, 6);
        send(2'b01, 10);
        wait_idle();
        chk("t2_exp_q_wrap", exp_q, 252);
        send(2'b10, 3);
        send(2'b00, 2);
        wait_idle();
        chk("t3_exp_q", exp_q, 5);
        send(2'b11, 0);
        send(2'b00, 0);
        wait_idle();
        chk("t4_exp_q", exp_q, 0);
        send(2'b01, 1);
        wait_idle();
        chk("t4_wrap_down", exp_q, 255);
        send(2'b00, 1);
        wait_idle();
        chk("t4_wrap_up", exp_q, 0);

        // Random command stream, sometimes back-to-back
        for (int i = 0; i < 30; i++) begin
            logic [1:0] op;
            int         arg;
            op  = 2'($urandom_range(0, 3));
            arg = (op < 2) ? int'($urandom_range(0, 25)) : int'($urandom_range(0, 255));
            send(op, arg);
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();
        chk("rand_err", err, 0);
        chk("rand_err_cnt", err_cnt, 0);

        // Fault injection: three flipped cycles, then a clear that coincides with a mismatch
        @(negedge clk);
        flip = 8'h01;
        repeat (3) @(negedge clk);
        flip = 8'h00;
        chk("t5_err", err, 1);
        chk("t5_err_cnt", err_cnt, 3);
        flip    = 8'h01;
        err_clr = 1'b1;
        @(negedge clk);
        flip    = 8'h00;
        err_clr = 1'b0;
        chk("t5_clr_err", err, 0);
        chk("t5_clr_cnt", err_cnt, 0);
        chk_en = 1'b0;
        flip   = 8'h80;
        repeat (4) @(negedge clk);
        chk("t5_chk_off", err_cnt, 0);
        chk_en = 1'b1;
        repeat (260) @(negedge clk);
        flip = 8'h00;
        chk("t5_saturate", err_cnt, 255);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t5_sat_clr", {err, err_cnt}, 0);

        // Reset in the middle of a long count aborts it without a done pulse
        send(2'b00, 20);
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_ctl_zero", {syn_clr, load, en, up, busy, done}, 0);
        chk("t6_exp_q", exp_q, 0);
        chk("t6_ready", cif.cmd_ready, 1);
        sb.delete();
        mv = 0;
        begin
            int seen;
            seen = done_seen;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            repeat (8) @(negedge clk);
            chk("t6_no_done", done_seen, seen);
        end
        chk("t6_ready_after", cif.cmd_ready, 1);
        chk("t6_exp_after", exp_q, 0);
        chk("t6_busy_after", busy, 0);
        send(2'b00, 4);
        wait_idle();
        chk("t6_resume", exp_q, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
